// File: rtl/sum_9bit_sm.sv
// Registered 9-bit sign-magnitude adder/subtractor with one-cycle latency.
// Define SUM9_SATURATE_EN to saturate on magnitude overflow; otherwise the magnitude wraps.
module sum_9bit_sm (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  input  logic       sub,
  input  logic [8:0] inputA,
  input  logic [8:0] inputB,
  output logic [8:0] out,
  output logic       out_valid,
  output logic       overflow
);

  localparam int unsigned MAG_W = 8;

  logic [MAG_W-1:0] w_mag_a;
  logic [MAG_W-1:0] w_mag_b;
  logic             w_sign_a;
  logic             w_sign_b;
  logic [MAG_W:0]   w_sum;
  logic [MAG_W-1:0] w_mag;
  logic             w_sign;
  logic             w_ovf;

  assign w_mag_a  = inputA[MAG_W-1:0];
  assign w_mag_b  = inputB[MAG_W-1:0];
  // A zero-magnitude operand counts as +0 regardless of its sign bit
  assign w_sign_a = inputA[MAG_W] & (|w_mag_a);
  assign w_sign_b = (inputB[MAG_W] ^ sub) & (|w_mag_b);
  assign w_sum    = (MAG_W+1)'(w_mag_a) + (MAG_W+1)'(w_mag_b);

  always_comb begin
    w_mag  = '0;
    w_sign = 1'b0;
    w_ovf  = 1'b0;
    if (w_sign_a == w_sign_b) begin
      w_sign = w_sign_a;
      w_ovf  = w_sum[MAG_W];
`ifdef SUM9_SATURATE_EN
      w_mag  = w_sum[MAG_W] ? {MAG_W{1'b1}} : w_sum[MAG_W-1:0];
`else
      w_mag  = w_sum[MAG_W-1:0];
`endif
    end else if (w_mag_a > w_mag_b) begin
      w_mag  = w_mag_a - w_mag_b;
      w_sign = w_sign_a;
    end else if (w_mag_b > w_mag_a) begin
      w_mag  = w_mag_b - w_mag_a;
      w_sign = w_sign_b;
    end
    // Never emit -0, including a wrapped zero
    if (w_mag == '0) begin
      w_sign = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out       <= '0;
      out_valid <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        out      <= {w_sign, w_mag};
        overflow <= w_ovf;
      end
    end
  end

endmodule

// File: tb/tb_sum_9bit_sm.sv
// Directed self-checking bench for sum_9bit_sm; expectations follow SUM9_SATURATE_EN.
module tb_sum_9bit_sm;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       sub;
  logic [8:0] inputA;
  logic [8:0] inputB;
  logic [8:0] out;
  logic       out_valid;
  logic       overflow;

  int n_cmp;
  int n_err;

  sum_9bit_sm dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .sub       (sub),
    .inputA    (inputA),
    .inputB    (inputB),
    .out       (out),
    .out_valid (out_valid),
    .overflow  (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one vector at the falling edge, sample 1 ns after the next rising edge
  task automatic run_vec(input logic [8:0] a, input logic [8:0] b, input logic s,
                         input logic [8:0] exp_out, input logic exp_ovf, input string name);
    @(negedge clk);
    inputA   = a;
    inputB   = b;
    sub      = s;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    n_cmp++;
    if (out !== exp_out) begin
      n_err++;
      $display("FAIL %s out: got %h expected %h", name, out, exp_out);
    end
    n_cmp++;
    if (overflow !== exp_ovf) begin
      n_err++;
      $display("FAIL %s overflow: got %b expected %b", name, overflow, exp_ovf);
    end
    n_cmp++;
    if (out_valid !== 1'b1) begin
      n_err++;
      $display("FAIL %s out_valid: got %b expected 1", name, out_valid);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    run_vec(9'h003, 9'h002, 1'b0, 9'h005, 1'b0, "pre_reset");
    @(negedge clk);
    inputA   = 9'h0C8;
    inputB   = 9'h064;
    in_valid = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (out !== 9'h000 || out_valid !== 1'b0 || overflow !== 1'b0) begin
      n_err++;
      $display("FAIL reset_async: got out=%h v=%b ovf=%b expected 000/0/0", out, out_valid, overflow);
    end
    @(posedge clk);
    #1;
    n_cmp++;
    if (out !== 9'h000 || out_valid !== 1'b0 || overflow !== 1'b0) begin
      n_err++;
      $display("FAIL reset_held: got out=%h v=%b ovf=%b expected 000/0/0", out, out_valid, overflow);
    end
    @(negedge clk);
    rst_n    = 1'b1;
    in_valid = 1'b0;
    run_vec(9'h010, 9'h020, 1'b0, 9'h030, 1'b0, "post_reset");
  endtask

  task automatic test_basic_signs();
    logic [8:0] a_t [4] = '{9'h003, 9'h003, 9'h103, 9'h103};
    logic [8:0] b_t [4] = '{9'h002, 9'h102, 9'h002, 9'h102};
    logic [8:0] e_t [4] = '{9'h005, 9'h001, 9'h101, 9'h105};
    for (int i = 0; i < 4; i++) begin
      run_vec(a_t[i], b_t[i], 1'b0, e_t[i], 1'b0, $sformatf("basic_%0d", i));
    end
  endtask

  task automatic test_cancel_negzero();
    run_vec(9'h105, 9'h005, 1'b0, 9'h000, 1'b0, "cancel");
    run_vec(9'h100, 9'h100, 1'b0, 9'h000, 1'b0, "negzero_both");
    run_vec(9'h100, 9'h007, 1'b0, 9'h007, 1'b0, "negzero_a");
  endtask

  task automatic test_subtract();
    run_vec(9'h003, 9'h005, 1'b1, 9'h102, 1'b0, "sub_neg");
    run_vec(9'h103, 9'h103, 1'b1, 9'h000, 1'b0, "sub_zero");
    run_vec(9'h005, 9'h100, 1'b1, 9'h005, 1'b0, "sub_negzero_b");
    run_vec(9'h10A, 9'h004, 1'b1, 9'h10E, 1'b0, "sub_neg_a");
  endtask

  task automatic test_overflow();
`ifdef SUM9_SATURATE_EN
    run_vec(9'h0C8, 9'h064, 1'b0, 9'h0FF, 1'b1, "ovf_pos");
    run_vec(9'h1FF, 9'h101, 1'b0, 9'h1FF, 1'b1, "ovf_neg");
    run_vec(9'h180, 9'h080, 1'b1, 9'h1FF, 1'b1, "ovf_sub");
`else
    run_vec(9'h0C8, 9'h064, 1'b0, 9'h02C, 1'b1, "ovf_pos");
    run_vec(9'h1FF, 9'h101, 1'b0, 9'h000, 1'b1, "ovf_neg");
    run_vec(9'h180, 9'h080, 1'b1, 9'h000, 1'b1, "ovf_sub");
`endif
    run_vec(9'h0FF, 9'h1FF, 1'b0, 9'h000, 1'b0, "max_cancel");
    run_vec(9'h0FF, 9'h000, 1'b0, 9'h0FF, 1'b0, "max_no_ovf");
  endtask

  task automatic test_hold();
    logic [8:0] exp_out;
`ifdef SUM9_SATURATE_EN
    exp_out = 9'h0FF;
`else
    exp_out = 9'h02C;
`endif
    run_vec(9'h0C8, 9'h064, 1'b0, exp_out, 1'b1, "hold_setup");
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      in_valid = 1'b0;
      inputA   = 9'h011;
      inputB   = 9'h022;
      @(posedge clk);
      #1;
      n_cmp++;
      if (out !== exp_out || overflow !== 1'b1 || out_valid !== 1'b0) begin
        n_err++;
        $display("FAIL hold_%0d: got out=%h ovf=%b v=%b expected %h/1/0", i, out, overflow, out_valid, exp_out);
      end
    end
  endtask

  initial begin
    n_cmp    = 0;
    n_err    = 0;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    sub      = 1'b0;
    inputA   = '0;
    inputB   = '0;
    #1;
    n_cmp++;
    if (out !== 9'h000 || out_valid !== 1'b0 || overflow !== 1'b0) begin
      n_err++;
      $display("FAIL initial_reset: got out=%h v=%b ovf=%b expected 000/0/0", out, out_valid, overflow);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    test_reset();
    test_basic_signs();
    test_cancel_negzero();
    test_subtract();
    test_overflow();
    test_hold();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/sum_9bit_sm.md
Name: sum_9bit_sm

Overview:
Registered 9-bit sign-magnitude adder/subtractor for the ALU datapath.
- Operand format: bit 8 is the sign (1 = negative), bits 7:0 are the unsigned magnitude.
- Takes two operands plus an optional subtract request and returns the sign-magnitude sum one clock later.
- Also reports magnitude overflow and output validity.

Parameters:
- None. Width is fixed at 9 bits: 1 sign bit + 8 magnitude bits.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous reset, active-low.
- in_valid  input  1  operands valid this cycle.
- sub  input  1  1 = compute inputA - inputB (invert the effective sign of B); 0 = add.
- inputA  input  9  operand A, sign-magnitude.
- inputB  input  9  operand B, sign-magnitude.
- out  output  9  result, sign-magnitude, registered.
- out_valid  output  1  out is valid; in_valid delayed one cycle.
- overflow  output  1  magnitude of the true result exceeded 255; registered alongside out.

Behaviour:
- Interface: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset: while rst_n = 0, out = 9'h000, out_valid = 0, overflow = 0, immediately and independent of clk. Asserting reset mid-operation discards the in-flight result.
- Latency: exactly 1 cycle.
  - If in_valid = 1 at rising edge N, the result appears on out/overflow after edge N with out_valid = 1.
  - out_valid tracks in_valid delayed by one cycle.
- Throughput: one operation per cycle; back-to-back valids are allowed. There is no backpressure.
- Hold: when in_valid = 0 at an edge, out and overflow hold their previous values and out_valid = 0.
- Effective operands: sA = inputA[8], mA = inputA[7:0]; sB = inputB[8] XOR sub, mB = inputB[7:0].
- Negative-zero inputs: an operand with magnitude 0 is treated as +0 whatever its sign bit.
- Same signs (sA == sB):
  - 9-bit magnitude sum = mA + mB; result sign = sA.
  - If the sum > 255, overflow = 1 and the magnitude is handled per the Optional Feature; otherwise overflow = 0.
- Different signs:
  - If mA > mB: magnitude = mA - mB, sign = sA.
  - If mB > mA: magnitude = mB - mA, sign = sB.
  - If mA == mB: result is +0 (9'h000).
  - overflow = 0 (cannot overflow).
- Zero normalisation: the output is never -0. Any zero-magnitude result has sign 0; this applies to saturated/wrapped zero too.
- No internal state beyond the three output registers. The datapath is combinational ahead of the output register.

Optional Feature:
- Macro: SUM9_SATURATE_EN.
- Defined: on magnitude overflow, the output magnitude saturates to 8'hFF with the correct sign (e.g. 200 + 100 -> +255, out = 9'h0FF).
- Not defined: on magnitude overflow, the output magnitude wraps to the low 8 bits of the sum (e.g. 200 + 100 -> magnitude 44, out = 9'h02C). A wrapped zero is forced to +0.
- overflow = 1 in both builds whenever the true magnitude exceeds 255.

Test Plan:
- Reset: assert rst_n = 0 mid-stream with in_valid = 1 -> out = 9'h000, out_valid = 0, overflow = 0 immediately; first valid after release yields a result one cycle later.
- Basic signs, sub = 0, back-to-back in_valid (out_valid stays 1, one result per cycle):
  - 9'h003 + 9'h002 -> 9'h005
  - 9'h003 + 9'h102 -> 9'h001
  - 9'h103 + 9'h002 -> 9'h101
  - 9'h103 + 9'h102 -> 9'h105
- Cancellation and negative zero:
  - 9'h105 + 9'h005 -> 9'h000
  - 9'h100 + 9'h100 -> 9'h000
  - 9'h100 + 9'h007 -> 9'h007
  - overflow = 0 in all three cases.
- Subtract: sub = 1, 9'h003 - 9'h005 -> 9'h102; sub = 1, 9'h103 - 9'h103 -> 9'h000.
- Overflow, 9'h0C8 + 9'h064:
  - Built with SUM9_SATURATE_EN: out = 9'h0FF, overflow = 1.
  - Built without it: out = 9'h02C, overflow = 1.
  - Negative case 9'h1FF + 9'h101, saturating build: out = 9'h1FF, overflow = 1.
- Hold: in_valid = 0 for 3 cycles after a result -> out and overflow unchanged, out_valid = 0.
